// File: rtl/rx_capture_ofdm.sv
// Receive capture buffer: stores one frame of demapped 4-bit OFDM symbols, then drains it over valid/ready.
// Optional OFDM_SOP_RESYNC_EN: a sop with valid_in during capture restarts the frame at address 0.
module rx_capture_ofdm #(
   parameter int ADDR_WIDTH = 12,
   parameter int FRAME_LEN  = 4096
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       sop,
   input  logic       valid_in,
   input  logic       mod_switch,
   input  logic [3:0] data_in,
   input  logic       ready_in,
   output logic [3:0] data_out,
   output logic       valid_out,
   output logic       mod_out,
   output logic       frame_done,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

   localparam logic [ADDR_WIDTH:0] FRAME_LAST = (ADDR_WIDTH + 1)'(FRAME_LEN - 1);
   localparam logic [ADDR_WIDTH:0] FRAME_END  = (ADDR_WIDTH + 1)'(FRAME_LEN);

   state_t              r_state;
   logic [ADDR_WIDTH:0] r_wr_ptr;
   logic [ADDR_WIDTH:0] r_rd_ptr;
   logic                r_mod_out;
   logic [3:0]          r_data_out;
   logic                r_valid_out;
   logic                r_frame_done;
   logic                r_busy;
   logic                r_overrun;
   logic [3:0]          r_ram_q;
   logic                r_s1_valid;
   logic [3:0]          r_mem [0:(2**ADDR_WIDTH)-1];

   logic                w_cap_start;
   logic                w_resync;
   logic                w_restart;
   logic                w_wr_en;
   logic [ADDR_WIDTH:0] w_wr_addr;
   logic                w_wr_mod;
   logic [3:0]          w_wr_data;
   logic                w_wr_last;
   logic                w_adv;
   logic                w_rd_en;
   logic                w_last_xfer;

   assign w_cap_start = (r_state == S_ARMED) && sop && valid_in;
`ifdef OFDM_SOP_RESYNC_EN
   assign w_resync    = (r_state == S_CAPTURE) && sop && valid_in;
`else
   assign w_resync    = 1'b0;
`endif
   assign w_restart   = w_cap_start || w_resync;
   assign w_wr_en     = w_cap_start || ((r_state == S_CAPTURE) && valid_in);
   assign w_wr_addr   = w_restart ? '0 : r_wr_ptr;
   // A (re)starting frame takes its modulation from the live input, not the latched copy
   assign w_wr_mod    = w_restart ? mod_switch : r_mod_out;
   assign w_wr_data   = w_wr_mod ? data_in : {2'b00, data_in[1:0]};
   assign w_wr_last   = w_wr_en && (w_wr_addr == FRAME_LAST);

   // Two-stage read pipe (RAM register, output register) advances whenever the output slot frees up
   assign w_adv       = !r_valid_out || ready_in;
   assign w_rd_en     = (r_state == S_DRAIN) && w_adv && (r_rd_ptr < FRAME_END);
   assign w_last_xfer = r_valid_out && ready_in && !r_s1_valid && (r_rd_ptr == FRAME_END);

   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr[ADDR_WIDTH-1:0]] <= w_wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (w_rd_en) begin
         r_ram_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_mod_out    <= 1'b0;
         r_data_out   <= '0;
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
         r_s1_valid   <= 1'b0;
      end else if (!enable) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
         r_s1_valid   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_state <= S_ARMED;
            end
            S_ARMED, S_CAPTURE: begin
               if (w_wr_en) begin
                  r_wr_ptr <= w_wr_addr + 1'b1;
                  if (w_restart) begin
                     r_mod_out <= mod_switch;
                  end
                  if (w_wr_last) begin
                     r_state      <= S_DRAIN;
                     r_frame_done <= 1'b1;
                     r_rd_ptr     <= '0;
                     r_s1_valid   <= 1'b0;
                     r_valid_out  <= 1'b0;
                  end else begin
                     r_state <= S_CAPTURE;
                  end
                  r_busy <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (valid_in) begin
                  r_overrun <= 1'b1;
               end
               if (w_last_xfer) begin
                  r_state     <= S_ARMED;
                  r_busy      <= 1'b0;
                  r_valid_out <= 1'b0;
                  r_s1_valid  <= 1'b0;
                  r_rd_ptr    <= '0;
                  r_wr_ptr    <= '0;
               end else if (w_adv) begin
                  r_s1_valid  <= w_rd_en;
                  r_valid_out <= r_s1_valid;
                  r_data_out  <= r_ram_q;
                  if (w_rd_en) begin
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign data_out   = r_data_out;
   assign valid_out  = r_valid_out;
   assign mod_out    = r_mod_out;
   assign frame_done = r_frame_done;
   assign busy       = r_busy;
   assign overrun    = r_overrun;

endmodule

// File: doc/rx_capture_ofdm.md
Name: rx_capture_ofdm

Overview:
- Receive-side counterpart of the transmit ROM symbol source.
- Captures one frame of demapped 4-bit OFDM symbols into on-chip RAM. The frame start is marked by sop; a write-address counter fills the RAM.
- After the frame is complete, the RAM is streamed back out over a valid/ready handshake for checking or host readout.
- Sits after the demapper, ahead of the compare/host interface.

Parameters:
- ADDR_WIDTH, 12, RAM address width; depth = 2**ADDR_WIDTH.
- FRAME_LEN, 4096, symbols per frame; legal range 1..2**ADDR_WIDTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable; low aborts and forces IDLE.
- sop  in  1  start-of-frame marker; qualified by valid_in.
- valid_in  in  1  data_in valid this cycle.
- mod_switch  in  1  0 = QPSK (2 bits/symbol), 1 = 16-QAM (4 bits/symbol).
- data_in  in  4  demapped symbol bits.
- ready_in  in  1  downstream ready for readout.
- data_out  out  4  readout symbol.
- valid_out  out  1  data_out valid.
- mod_out  out  1  mod_switch latched at frame sop.
- frame_done  out  1  one-cycle pulse when the last symbol is written.
- busy  out  1  high in CAPTURE or DRAIN.
- overrun  out  1  sticky; valid_in arrived while in DRAIN.

Behaviour:
- Reset and enable:
  - All outputs reset to 0; state reset to IDLE; write and read pointers reset to 0.
  - enable low at any cycle: next state IDLE, pointers cleared, valid_out = 0, overrun cleared. RAM contents are don't-care.
- States:
  - IDLE -> ARMED when enable = 1.
  - ARMED: waits for sop & valid_in. On that cycle it writes data_in to address 0, sets wr_ptr = 1, latches mod_out = mod_switch, and moves to CAPTURE. sop without valid_in is ignored.
  - CAPTURE: each valid_in writes at wr_ptr, then wr_ptr increments. sop in CAPTURE is handled per the optional feature.
  - CAPTURE end of frame: on the write to address FRAME_LEN-1, frame_done pulses high for exactly the following cycle and the state moves to DRAIN. With FRAME_LEN = 1, the sop write completes the frame and goes straight to DRAIN.
  - DRAIN read path: reads addresses 0..FRAME_LEN-1 in order. RAM read latency is 1 cycle. valid_out first asserts 2 cycles after DRAIN entry.
  - DRAIN handshake:
    - A transfer occurs when valid_out & ready_in.
    - data_out and valid_out are held stable while ready_in = 0.
    - No symbol may be dropped or duplicated.
    - Throughput is 1 symbol/cycle while ready_in is held high.
  - DRAIN exit: after the FRAME_LEN-th transfer, valid_out drops the next cycle and the state returns to ARMED.
- Stored value:
  - mod_out = 1: data_in unchanged.
  - mod_out = 0: {2'b00, data_in[1:0]}; upper bits are forced to 0.
  - mod_switch changes mid-frame are ignored.
- Overrun: valid_in during DRAIN is dropped, sets overrun, and does not disturb readout. overrun is cleared only by reset or enable low.
- Pointer rules:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide, so FRAME_LEN = 2**ADDR_WIDTH is legal.
  - There is no wrap within a frame; pointers clear on each new frame.
- busy = 1 in CAPTURE and DRAIN, 0 in IDLE and ARMED.

Optional Feature:
- Macro: OFDM_SOP_RESYNC_EN.
- Defined: sop & valid_in during CAPTURE restarts the frame. data_in is written to address 0, wr_ptr = 1, mod_out is re-latched, and there is no frame_done for the aborted frame.
- Undefined: sop in CAPTURE is ignored; the symbol is stored as ordinary data at wr_ptr.
- In DRAIN, sop is always treated as overrun data, with or without the macro.

Test Plan:
- FRAME_LEN = 8, mod_switch = 1, ready_in = 1:
  - Stimulus: sop, then symbols 0..7 on consecutive cycles.
  - Response: frame_done pulses the cycle after the 8th write; valid_out is high 8 consecutive cycles with data_out 0,1,…,7; state returns to ARMED (busy = 0).
- mod_switch = 0 at sop, data_in = 4'hF for all 8 symbols -> all readouts 4'h3, mod_out = 0.
- ready_in toggling 1,0,1,0 in DRAIN -> data_out stable during stalls; exactly 8 transfers with values 0..7, in order.
- valid_in pulsed during DRAIN -> overrun = 1 and stays set; readout still 0..7; overrun clears after enable is low for 1 cycle.
- Reset asserted after 3 captured symbols -> all outputs 0 the next cycle; a new sop plus 8 symbols A..H reads back A..H.
- sop asserted again after 3 writes:
  - OFDM_SOP_RESYNC_EN defined: first readout is the second-sop symbol; no frame_done until 8 writes after it.
  - OFDM_SOP_RESYNC_EN undefined: readout 4th value is the second-sop symbol; frame_done occurs after 8 total writes.
